// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider with its own control FSM, for the DIV/DIVU instructions.
// Define DIV_ZERO_FLAG_EN to build a registered div_zero flag; without it, div_zero is tied to 0.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall,
  output logic               div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   work;
  logic [WIDTH-1:0]   divisor;
  logic               q_neg;
  logic               r_neg;
  logic [WIDTH:0]     diff;
  logic               last_step;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && (v < 0)) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign last_step = (cnt == CNT_W'(WIDTH));
  // Trial subtraction; diff[WIDTH] set means a borrow, so the partial remainder is restored.
  assign diff      = {1'b0, work[2*WIDTH-1:WIDTH]} - {1'b0, divisor};
  assign stall     = start & ~ready & ~annul;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (opdata2 == '0) ? BY_ZERO : ON;
      BY_ZERO: state_nxt = END;
      ON:      if (last_step) state_nxt = END;
      END:     if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (annul) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ready  <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (annul) begin
        cnt    <= '0;
        ready  <= 1'b0;
        result <= '0;
      end else begin
        case (state)
          IDLE: begin
            ready <= 1'b0;
            if (start) cnt <= '0;
          end
          BY_ZERO: result <= '0;
          ON: begin
            if (!last_step) begin
              cnt <= cnt + CNT_W'(1);
            end else begin
              result <= {cond_neg(work[2*WIDTH:WIDTH+1], r_neg),
                         cond_neg(work[WIDTH-1:0], q_neg)};
              ready  <= 1'b1;
            end
          end
          // The divide-by-zero path enters END with ready low; it rises here one edge later.
          END: ready <= start;
          default: ;
        endcase
      end
    end
  end

  // ---- operand latch and restoring iteration (no reset needed) ----
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          q_neg   <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
          r_neg   <= signed_div & opdata1[WIDTH-1];
          divisor <= magnitude(opdata2, signed_div);
          work    <= {{WIDTH{1'b0}}, magnitude(opdata1, signed_div), 1'b0};
        end
      end
      ON: begin
        if (!last_step) begin
          work <= diff[WIDTH] ? {work[2*WIDTH-1:0], 1'b0}
                              : {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
        end
      end
      default: ;
    endcase
  end

`ifdef DIV_ZERO_FLAG_EN
  logic dz;

  always_ff @(posedge clk) begin
    if (rst || annul)                 dz <= 1'b0;
    else if (state == BY_ZERO)        dz <= 1'b1;
    else if (state == END && !start)  dz <= 1'b0;
  end

  assign div_zero = dz;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: latency, signed/unsigned results, divide-by-zero,
// cancellation by annul and rst, and back-to-back operation.
module tb_div_ctrl;
  localparam int WIDTH = 32;

`ifdef DIV_ZERO_FLAG_EN
  localparam logic DZ_EXP = 1'b1;
`else
  localparam logic DZ_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall;
  logic        div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .annul     (annul),
    .result    (result),
    .ready     (ready),
    .stall     (stall),
    .div_zero  (div_zero)
  );

  // Called at a falling edge; returns the index k of the edge Ek after which ready was seen.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output int lat, output logic [63:0] res, output logic stall_ok);
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    start      = 1'b1;
    lat        = -1;
    stall_ok   = 1'b1;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    res = result;
  endtask

  task automatic finish_div();
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int lat; logic [63:0] res; logic sok;
    run_div(32'd100, 32'd7, 1'b0, lat, res, sok);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL unsigned_latency got %0d want 33", lat); end
    n_checks++; if (res !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL unsigned_result got %h want %h", res, {32'd2, 32'd14}); end
    n_checks++; if (sok !== 1'b1) begin n_fail++; $display("FAIL unsigned_stall got %b want 1", sok); end
    finish_div();
  endtask

  task automatic test_signed();
    int lat; logic [63:0] res; logic sok;
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat, res, sok);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL signed_latency got %0d want 33", lat); end
    n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL signed_result got %h want ffffffff_fffffffd", res); end
    finish_div();
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, lat, res, sok);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu_latency got %0d want 33", lat); end
    n_checks++; if (res !== 64'h0000_0001_7FFF_FFFC) begin n_fail++; $display("FAIL divu_result got %h want 00000001_7ffffffc", res); end
    finish_div();
  endtask

  task automatic test_overflow();
    int lat; logic [63:0] res; logic sok;
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, res, sok);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL overflow_latency got %0d want 33", lat); end
    n_checks++; if (res !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL overflow_result got %h want 00000000_80000000", res); end
    finish_div();
  endtask

  task automatic test_annul();
    int lat; logic [63:0] res; logic sok;
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL annul_busy_stall got %b want 1", stall); end
    annul = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL annul_stall got %b want 0", stall); end
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL annul_ready got %b want 0", ready); end
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL annul_result got %h want 0", result); end
    annul = 1'b0; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    run_div(32'd9, 32'd3, 1'b0, lat, res, sok);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL annul_restart_latency got %0d want 33", lat); end
    n_checks++; if (res !== {32'd0, 32'd3}) begin n_fail++; $display("FAIL annul_restart_result got %h want 00000000_00000003", res); end
    finish_div();
  endtask

  task automatic test_rst_cancel();
    int lat; logic [63:0] res; logic sok;
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", ready); end
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL rst_result got %h want 0", result); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL rst_div_zero got %b want 0", div_zero); end
    rst = 1'b0; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    run_div(32'd15, 32'd4, 1'b0, lat, res, sok);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL rst_restart_latency got %0d want 33", lat); end
    finish_div();
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] res; logic sok;
    run_div(32'd100, 32'd7, 1'b0, lat, res, sok);
    n_checks++; if (res !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL b2b_first_result got %h want 00000002_0000000e", res); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (result !== {32'd2, 32'd14} || ready !== 1'b1) begin n_fail++; $display("FAIL b2b_hold result %h ready %b want 00000002_0000000e ready 1", result, ready); end
    end
    finish_div();
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_drop_ready got %b want 0", ready); end
    n_checks++; if (result !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL b2b_drop_result got %h want 00000002_0000000e", result); end
    run_div(32'd15, 32'd4, 1'b0, lat, res, sok);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 33", lat); end
    n_checks++; if (res !== {32'd3, 32'd3}) begin n_fail++; $display("FAIL b2b_second_result got %h want 00000003_00000003", res); end
    finish_div();
  endtask

  task automatic test_div_zero();
    int lat; logic [63:0] res; logic sok;
    run_div(32'h0000_1234, 32'd0, 1'b1, lat, res, sok);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL divzero_latency got %0d want 2", lat); end
    n_checks++; if (res !== 64'd0) begin n_fail++; $display("FAIL divzero_result got %h want 0", res); end
    n_checks++; if (div_zero !== DZ_EXP) begin n_fail++; $display("FAIL divzero_flag got %b want %b", div_zero, DZ_EXP); end
    finish_div();
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL divzero_flag_clear got %b want 0", div_zero); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL divzero_ready_clear got %b want 0", ready); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_annul();
    test_rst_cancel();
    test_back_to_back();
    test_div_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
